// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops with a registered result, plus iterative unsigned
// multiply (shift-add) and divide (restoring) producing a HI/LO pair, valid/ready on both sides.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] HiResult,
  output logic             Zero,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_ZERO = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  // acc: partial-product high half (MUL) or running remainder (DIV)
  // lo : multiplier shifting out (MUL) or dividend shifting out / quotient shifting in (DIV)
  // opd: multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc, lo, opd;
  logic             accept, is_long;
  logic [WIDTH-1:0] res_single;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_lo;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_fit;
  logic [WIDTH-1:0] div_acc, div_lo;
  logic [WIDTH-1:0] step_acc, step_lo;

  generate
    if (SHW + 6 <= WIDTH) begin : g_shamt_field
      assign shamt = B[SHW+5:6];
    end else begin : g_shamt_low
      assign shamt = B[SHW-1:0];
    end
  endgenerate

  assign is_long = (ALUControl == OP_MULU) || (ALUControl == OP_DIVU);
  assign accept  = InValid && InReady;
  assign Zero    = ~|ALUResult;

  always_comb begin
    res_single = '0;
    case (ALUControl)
      OP_AND:  res_single = A & B;
      OP_OR:   res_single = A | B;
      OP_ADD:  res_single = A + B;
      OP_NOR:  res_single = ~(A | B);
      OP_SUB:  res_single = A - B;
      OP_SLT:  res_single = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_ZERO: res_single = '0;
      OP_SLL:  res_single = A << shamt;
      OP_SRL:  res_single = A >> shamt;
      OP_SRA:  res_single = $signed(A) >>> shamt;
      default: res_single = '0;
    endcase
  end

  // One iteration of each long op; the final iteration's values go straight to the outputs.
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opd} : '0);
    mul_acc   = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo[WIDTH-1:1]};
    div_shift = {acc, lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opd};
    div_fit   = ~div_diff[WIDTH+1];
    div_acc   = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {lo[WIDTH-2:0], div_fit};
    step_acc  = (state == DIV) ? div_acc : mul_acc;
    step_lo   = (state == DIV) ? div_lo  : mul_lo;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        InReady = !OutValid || OutReady;
        if (InValid && InReady) begin
          if (ALUControl == OP_MULU)      state_nxt = MUL;
          else if (ALUControl == OP_DIVU) state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        Busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= '0;
      acc       <= '0;
      lo        <= '0;
      opd       <= '0;
      ALUResult <= '0;
      HiResult  <= '0;
      OutValid  <= 1'b0;
    end else if (accept) begin
      if (is_long) begin
        cnt      <= CW'(WIDTH);
        acc      <= '0;
        opd      <= (ALUControl == OP_MULU) ? A : B;
        lo       <= (ALUControl == OP_MULU) ? B : A;
        OutValid <= 1'b0;
      end else begin
        ALUResult <= res_single;
        HiResult  <= '0;
        OutValid  <= 1'b1;
      end
    end else if (state != IDLE) begin
      cnt <= cnt - CW'(1);
      acc <= step_acc;
      lo  <= step_lo;
      if (cnt == CW'(1)) begin
        ALUResult <= step_lo;
        HiResult  <= step_acc;
        OutValid  <= 1'b1;
      end
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases from the datasheet plus random traffic, all
// checked every cycle against a transaction-level model (plain arithmetic, cycle counts).
module tb_alu_multicycle;
  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          InValid, InReady, OutValid, OutReady, Zero, Busy;
  logic [3:0]    ALUControl;
  logic [W-1:0]  A, B, ALUResult, HiResult;

  alu_multicycle #(.WIDTH(W), .SHW(5)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .A(A), .B(B), .OutValid(OutValid),
    .OutReady(OutReady), .ALUResult(ALUResult), .HiResult(HiResult),
    .Zero(Zero), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  // model state: result register contents and remaining cycles of a long op
  bit           m_valid;
  logic [W-1:0] m_lo, m_hi, p_lo, p_hi;
  int           m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_calc(input logic [3:0] op, input logic [W-1:0] a, b,
                                   output logic [W-1:0] lo, output logic [W-1:0] hi);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[10:6];
    hi = '0;
    lo = '0;
    case (op)
      4'd0:  lo = a & b;
      4'd1:  lo = a | b;
      4'd2:  lo = a + b;
      4'd3:  lo = ~(a | b);
      4'd6:  lo = a - b;
      4'd7:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: lo = a << sh;
      4'd11: lo = a >> sh;
      4'd12: lo = $signed(a) >>> sh;
      4'd9: begin
        p  = {32'b0, a} * {32'b0, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      4'd13: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: lo = '0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", OutValid, m_valid);
    chk("busy", Busy, m_busy > 0);
    if (m_valid) begin
      chk("lo", ALUResult, m_lo);
      chk("hi", HiResult, m_hi);
      chk("zero", Zero, m_lo == 0);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge), advance the model
  // across the next rising edge, then check outputs on the following falling edge.
  task automatic cycle(input logic iv, input logic [3:0] op, input logic [W-1:0] a, b,
                       input logic ordy);
    bit           exp_ready, nv;
    logic [W-1:0] lo, hi;
    InValid = iv; ALUControl = op; A = a; B = b; OutReady = ordy;
    #1;
    exp_ready = (m_busy == 0) && (!m_valid || ordy);
    chk("in_ready", InReady, exp_ready);
    nv = m_valid && !ordy;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin nv = 1; m_lo = p_lo; m_hi = p_hi; end
    end
    if (iv && exp_ready) begin
      ref_calc(op, a, b, lo, hi);
      if (op == 4'd9 || op == 4'd13) begin
        m_busy = W; p_lo = lo; p_hi = hi;
      end else begin
        nv = 1; m_lo = lo; m_hi = hi;
      end
    end
    m_valid = nv;
    @(posedge Clk);
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd2, $urandom, $urandom, ordy);
  endtask

  task automatic model_reset();
    m_valid = 0; m_lo = '0; m_hi = '0; m_busy = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", OutValid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_lo", ALUResult, 32'd0);
    chk("rst_hi", HiResult, 32'd0);
    chk("rst_zero", Zero, 1'b1);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] ra, rb;
    Rst = 1'b1; InValid = 0; ALUControl = 0; A = 0; B = 0; OutReady = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_reset_values();
    Rst = 1'b0;

    // ADD 5+7
    cycle(1, 4'd2, 32'd5, 32'd7, 1);
    chk("add_lit", ALUResult, 32'd12);
    chk("add_zero_lit", Zero, 1'b0);
    chk("add_hi_lit", HiResult, 32'd0);
    // SLT -5 < 3
    cycle(1, 4'd7, 32'hFFFF_FFFB, 32'd3, 1);
    chk("slt_lit", ALUResult, 32'd1);
    // SUB equal -> zero
    cycle(1, 4'd6, 32'h1234, 32'h1234, 1);
    chk("sub_lit", ALUResult, 32'd0);
    chk("sub_zero_lit", Zero, 1'b1);
    // unused op code
    cycle(1, 4'd4, 32'd5, 32'd7, 1);
    chk("op4_lit", ALUResult, 32'd0);
    // shifts with shamt taken from B[10:6]
    cycle(1, 4'd12, 32'h8000_0000, 32'd4 << 6, 1);
    chk("sra_lit", ALUResult, 32'hF800_0000);

    // MULTU, result held for a few cycles before consumption
    cycle(1, 4'd9, 32'hFFFF_FFFF, 32'd2, 1);
    idle(W, 0);
    chk("mul_lo_lit", ALUResult, 32'hFFFF_FFFE);
    chk("mul_hi_lit", HiResult, 32'd1);
    idle(2, 0);
    idle(1, 1);

    // DIVU 100/7, then divide by zero
    cycle(1, 4'd13, 32'd100, 32'd7, 1);
    idle(W, 0);
    chk("div_q_lit", ALUResult, 32'd14);
    chk("div_r_lit", HiResult, 32'd2);
    cycle(1, 4'd13, 32'd9, 32'd0, 1);
    idle(W, 0);
    chk("div0_q_lit", ALUResult, 32'hFFFF_FFFF);
    chk("div0_r_lit", HiResult, 32'd9);

    // back-pressure: held for 5 cycles, then consume and accept on the same edge
    cycle(1, 4'd2, 32'd3, 32'd4, 1);
    for (int i = 0; i < 5; i++) cycle(1, 4'd2, 32'd9, 32'd9, 0);
    chk("hold_lit", ALUResult, 32'd7);
    cycle(1, 4'd0, 32'hF0, 32'h3C, 1);
    chk("swap_lit", ALUResult, 32'h30);
    chk("swap_valid_lit", OutValid, 1'b1);

    // reset in the middle of a MULTU
    cycle(1, 4'd9, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    idle(9, 1);
    #2 Rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(negedge Clk);
    Rst = 1'b0;
    cycle(1, 4'd2, 32'd1, 32'd1, 1);
    chk("post_rst_add_lit", ALUResult, 32'd2);
    chk("post_rst_hi_lit", HiResult, 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      cycle(1'($urandom_range(0, 2) != 0), op, ra, rb, 1'($urandom_range(0, 3) != 0));
    end
    idle(W + 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
